// File: rtl/fnn_layer_sequencer_if.sv
// Purpose: config, input-vector and result handshake bundle of the FNN layer sequencer.
// Latency: none (wires only).
// Backpressure: in_ready/out_ready valid-ready pairs; cfg port has no backpressure, cfg_err flags drops.
interface fnn_layer_sequencer_if #(
   parameter int NEURONS = 4,
   parameter int CFG_AW  = 7
);
   logic                   cfg_we;
   logic [CFG_AW-1:0]      cfg_addr;
   logic [7:0]             cfg_wdata;
   logic                   cfg_err;
   logic                   in_valid;
   logic                   in_ready;
   logic [8*NEURONS-1:0]   in_data;
   logic                   out_valid;
   logic                   out_ready;
   logic [8*NEURONS-1:0]   out_data;
   logic                   busy;

   modport master (
      output cfg_we, cfg_addr, cfg_wdata, in_valid, in_data, out_ready,
      input  cfg_err, in_ready, out_valid, out_data, busy
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_wdata, in_valid, in_data, out_ready,
      output cfg_err, in_ready, out_valid, out_data, busy
   );
endinterface

// File: rtl/fnn_layer_sequencer.sv
// Purpose: one signed MAC time-multiplexed over all layers/neurons/inputs of a small FNN, with its own weight/bias store.
// Latency: LAYERS*NEURONS*(NEURONS+1) cycles from input accept edge to out_valid (80 with defaults).
// Backpressure: in_ready low from accept until the result is taken; out_valid/out_data held until out_ready.
module fnn_layer_sequencer #(
   parameter int NEURONS = 4,
   parameter int LAYERS  = 4,
   parameter int ACC_W   = 20,
   parameter int CFG_AW  = 7
) (
   input  logic                 clk,
   input  logic                 reset_n,
   fnn_layer_sequencer_if.slave bus
);
   localparam int PER_L = NEURONS * NEURONS + NEURONS;
   localparam int CFG_N = LAYERS * PER_L;
   localparam int IW    = (NEURONS > 1) ? $clog2(NEURONS) : 1;
   localparam int LW    = (LAYERS > 1) ? $clog2(LAYERS) : 1;

   typedef enum logic [1:0] {IDLE, MAC, ACT, DONE} state_t;

   state_t                  state;
   logic [7:0]              mem     [CFG_N];
   logic [7:0]              act_buf [NEURONS];
   logic [7:0]              nxt_buf [NEURONS];
   logic signed [ACC_W-1:0] acc;
   logic [LW-1:0]           l;
   logic [IW-1:0]           i;
   logic [IW-1:0]           j;

   logic [CFG_AW-1:0]       w_idx;
   logic [CFG_AW-1:0]       b_idx;
   logic                    addr_ok;
   logic signed [16:0]      prod;
   logic signed [ACC_W-1:0] acc_base;
   logic signed [ACC_W-1:0] acc_nxt;
   logic [7:0]              r;
   logic [8*NEURONS-1:0]    new_vec;

   // Store addressing for the current (l,i,j) and range check for host writes.
   always_comb begin
      w_idx   = CFG_AW'(l) * CFG_AW'(PER_L) + CFG_AW'(i) * CFG_AW'(NEURONS) + CFG_AW'(j);
      b_idx   = CFG_AW'(l) * CFG_AW'(PER_L) + CFG_AW'(NEURONS * NEURONS) + CFG_AW'(i);
      addr_ok = (bus.cfg_addr < CFG_AW'(CFG_N));
   end

   // MAC step: signed weight times unsigned activation, seeded with the bias on the first input.
   always_comb begin
      prod     = $signed(mem[w_idx]) * $signed({1'b0, act_buf[j]});
      acc_base = (j == '0) ? {{(ACC_W-8){mem[b_idx][7]}}, mem[b_idx]} : acc;
      acc_nxt  = acc_base + {{(ACC_W-17){prod[16]}}, prod};
   end

   // ReLU and clamp to 0..255, and the completed layer vector with the current neuron merged in.
   always_comb begin
      if (acc[ACC_W-1])
         r = 8'd0;
      else if (|acc[ACC_W-2:8])
         r = 8'hFF;
      else
         r = acc[7:0];
      new_vec = '0;
      for (int k = 0; k < NEURONS; k++)
         new_vec[8*k +: 8] = (IW'(k) == i) ? r : nxt_buf[k];
   end

   // Sequencer FSM, config store and all registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         bus.in_ready  <= 1'b1;
         bus.busy      <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.cfg_err   <= 1'b0;
         acc           <= '0;
         l             <= '0;
         i             <= '0;
         j             <= '0;
         for (int k = 0; k < CFG_N; k++)
            mem[k] <= '0;
         for (int k = 0; k < NEURONS; k++) begin
            act_buf[k] <= '0;
            nxt_buf[k] <= '0;
         end
      end else begin
         // Writes land only while idle; a same-edge accept therefore sees the new value.
         bus.cfg_err <= bus.cfg_we && ((state != IDLE) || !addr_ok);
         if (bus.cfg_we && (state == IDLE) && addr_ok)
            mem[bus.cfg_addr] <= bus.cfg_wdata;

         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  for (int k = 0; k < NEURONS; k++)
                     act_buf[k] <= bus.in_data[8*k +: 8];
                  l            <= '0;
                  i            <= '0;
                  j            <= '0;
                  bus.in_ready <= 1'b0;
                  bus.busy     <= 1'b1;
                  state        <= MAC;
               end
            end
            MAC: begin
               acc <= acc_nxt;
               if (j == IW'(NEURONS - 1))
                  state <= ACT;
               else
                  j <= j + 1'b1;
            end
            ACT: begin
               nxt_buf[i] <= r;
               j          <= '0;
               if (i != IW'(NEURONS - 1)) begin
                  i     <= i + 1'b1;
                  state <= MAC;
               end else begin
                  i <= '0;
                  for (int k = 0; k < NEURONS; k++)
                     act_buf[k] <= new_vec[8*k +: 8];
                  if (l != LW'(LAYERS - 1)) begin
                     l     <= l + 1'b1;
                     state <= MAC;
                  end else begin
                     bus.out_data  <= new_vec;
                     bus.out_valid <= 1'b1;
                     state         <= DONE;
                  end
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  bus.in_ready  <= 1'b1;
                  bus.busy      <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fnn_layer_sequencer.sv
// Purpose: bench for fnn_layer_sequencer: directed network cases plus randomized runs against a forward-pass model.
// Latency: checks the accept-to-result distance of 80 cycles.
// Backpressure: exercises held results, ignored inputs while busy, and rejected config writes.
module tb_fnn_layer_sequencer;
   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   fnn_layer_sequencer_if bus ();

   fnn_layer_sequencer dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   // Network parameters as seen by the host, plus expected handshake timeline.
   int          mw [4][4][4];
   int          mb [4][4];
   bit          m_busy, m_out_valid, m_cfg_err;
   int          m_cnt;
   int          ma;
   logic [31:0] m_out_data, m_pending;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Full forward pass with plain integer arithmetic.
   function automatic logic [31:0] forward(input logic [31:0] x);
      int a [4];
      int n [4];
      int s;
      logic [31:0] y;
      for (int j = 0; j < 4; j++) a[j] = int'(x[8*j +: 8]);
      for (int l = 0; l < 4; l++) begin
         for (int i = 0; i < 4; i++) begin
            s = mb[l][i];
            for (int j = 0; j < 4; j++) s += mw[l][i][j] * a[j];
            n[i] = (s < 0) ? 0 : ((s > 255) ? 255 : s);
         end
         a = n;
      end
      for (int i = 0; i < 4; i++) y[8*i +: 8] = 8'(a[i]);
      return y;
   endfunction

   // Reference model: host-visible behaviour advanced once per clock edge.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int l = 0; l < 4; l++)
            for (int i = 0; i < 4; i++) begin
               mb[l][i] = 0;
               for (int j = 0; j < 4; j++) mw[l][i][j] = 0;
            end
         m_busy = 0; m_out_valid = 0; m_cfg_err = 0; m_cnt = 0;
         m_out_data = '0; m_pending = '0;
      end else begin
         m_cfg_err = bus.cfg_we && (m_busy || (bus.cfg_addr >= 80));
         if (bus.cfg_we && !m_busy && (bus.cfg_addr < 80)) begin
            ma = int'(bus.cfg_addr);
            if ((ma % 20) < 16)
               mw[ma / 20][(ma % 20) / 4][ma % 4] = int'($signed(bus.cfg_wdata));
            else
               mb[ma / 20][(ma % 20) - 16] = int'($signed(bus.cfg_wdata));
         end
         if (!m_busy) begin
            if (bus.in_valid) begin
               m_busy    = 1;
               m_cnt     = 0;
               m_pending = forward(bus.in_data);
            end
         end else if (!m_out_valid) begin
            m_cnt++;
            if (m_cnt == 80) begin
               m_out_valid = 1;
               m_out_data  = m_pending;
            end
         end else if (bus.out_ready) begin
            m_out_valid = 0;
            m_busy      = 0;
         end
      end
   end

   // Compare DUT outputs against the model on every falling edge out of reset.
   always @(negedge clk) begin
      if (chk_en && reset_n) begin
         chk("in_ready",  32'(bus.in_ready),  32'(!m_busy));
         chk("busy",      32'(bus.busy),      32'(m_busy));
         chk("out_valid", 32'(bus.out_valid), 32'(m_out_valid));
         chk("cfg_err",   32'(bus.cfg_err),   32'(m_cfg_err));
         if (m_out_valid) chk("out_data", bus.out_data, m_out_data);
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wr(input int a, input logic [7:0] d);
      bus.cfg_we    = 1'b1;
      bus.cfg_addr  = 7'(a);
      bus.cfg_wdata = d;
      step();
      bus.cfg_we    = 1'b0;
   endtask

   task automatic set_layer(input int l, input logic [7:0] diag, input logic [7:0] off, input logic [7:0] bias);
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            wr(l * 20 + i * 4 + j, (i == j) ? diag : off);
      for (int i = 0; i < 4; i++) wr(l * 20 + 16 + i, bias);
   endtask

   // mode 0: quiet, 1: random noise on inputs while busy, 2: one config write at cycle 10.
   task automatic run(input logic [31:0] x, input int hold, input int mode,
                      output logic [31:0] y, output int lat);
      bus.in_valid = 1'b1;
      bus.in_data  = x;
      step();
      bus.in_valid = 1'b0;
      bus.cfg_we   = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 300) begin
         if (mode == 1) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_data   = $urandom;
            bus.cfg_we    = ($urandom_range(0, 7) == 0);
            bus.cfg_addr  = 7'($urandom_range(0, 127));
            bus.cfg_wdata = 8'($urandom);
         end else if (mode == 2) begin
            bus.cfg_we    = (lat == 10);
            bus.cfg_addr  = 7'd0;
            bus.cfg_wdata = 8'h55;
         end
         step();
         lat++;
         if (mode == 2 && lat == 11) chk("busy_write_err", 32'(bus.cfg_err), 32'd1);
      end
      bus.in_valid = 1'b0;
      bus.cfg_we   = 1'b0;
      if (!bus.out_valid) chk("out_valid_timeout", 32'(bus.out_valid), 32'd1);
      y = bus.out_data;
      repeat (hold) begin
         step();
         chk("hold_data", bus.out_data, y);
         chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
   endtask

   logic [31:0] y, x;
   int          lat;

   initial begin
      reset_n       = 1'b0;
      bus.cfg_we    = 1'b0;
      bus.cfg_addr  = '0;
      bus.cfg_wdata = '0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_busy",      32'(bus.busy),      32'd0);
      chk("rst_out_data",  bus.out_data,       32'd0);
      reset_n = 1'b1;
      chk_en  = 1'b1;
      step();

      // Identity network passes the input through after 80 cycles.
      for (int l = 0; l < 4; l++) set_layer(l, 8'h01, 8'h00, 8'h00);
      run(32'h04030201, 0, 0, y, lat);
      chk("identity", y, 32'h04030201);
      chk("latency", 32'(lat), 32'd80);

      // Large positive sums clamp to 255.
      set_layer(0, 8'h7F, 8'h7F, 8'h00);
      run(32'hFFFFFFFF, 0, 0, y, lat);
      chk("clamp", y, 32'hFFFFFFFF);

      // Negative sums are cut to zero.
      set_layer(0, 8'hFF, 8'h00, 8'h00);
      run(32'h04030201, 0, 0, y, lat);
      chk("relu", y, 32'h00000000);

      // Only the last layer's bias survives zero weights.
      for (int l = 0; l < 4; l++) set_layer(l, 8'h00, 8'h00, (l == 3) ? 8'h05 : 8'h00);
      run(32'h9A3C7E11, 0, 0, y, lat);
      chk("bias_only", y, 32'h05050505);

      // A write while busy is dropped and flagged.
      for (int l = 0; l < 4; l++) set_layer(l, 8'h01, 8'h00, 8'h00);
      run(32'h04030201, 0, 2, y, lat);
      chk("busy_write_ignored", y, 32'h04030201);
      wr(80, 8'h11);
      chk("range_err", 32'(bus.cfg_err), 32'd1);

      // Write on the accept edge is visible to that run: B[3][0] = 7.
      bus.cfg_we    = 1'b1;
      bus.cfg_addr  = 7'd76;
      bus.cfg_wdata = 8'h07;
      run(32'h04030201, 0, 0, y, lat);
      chk("same_edge_write", y, 32'h04030208);
      wr(76, 8'h00);

      // Result held under backpressure.
      run(32'h80402010, 10, 0, y, lat);
      chk("held_result", y, 32'h80402010);

      // Randomized networks with noise on the inputs while busy.
      for (int t = 0; t < 6; t++) begin
         for (int a = 0; a < 80; a++) wr(a, 8'($urandom_range(0, 40) - 20));
         x = $urandom;
         run(x, $urandom_range(0, 3), 1, y, lat);
         chk("rand_latency", 32'(lat), 32'd80);
      end

      // Reset in the middle of a run discards it and clears the store.
      for (int l = 0; l < 4; l++) set_layer(l, 8'h01, 8'h00, 8'h02);
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h11223344;
      step();
      bus.in_valid = 1'b0;
      repeat (39) step();
      reset_n = 1'b0;
      #1;
      chk("abort_in_ready",  32'(bus.in_ready),  32'd1);
      chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
      chk("abort_busy",      32'(bus.busy),      32'd0);
      chk("abort_cfg_err",   32'(bus.cfg_err),   32'd0);
      chk("abort_out_data",  bus.out_data,       32'd0);
      step();
      reset_n = 1'b1;
      step();
      run(32'hDEADBEEF, 0, 0, y, lat);
      chk("after_reset_cleared", y, 32'h00000000);

      repeat (3) step();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
